// File: rtl/fir_decim_fifo.sv
// Decimating averager for the FIR output stream. It feeds a small circular FIFO
// toward a ready/valid consumer. low_power_mode freezes the input side only.
module fir_decim_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DECIM = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [W-1:0]           in_data,
  input  logic                   low_power_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned SH    = $clog2(DECIM);
  localparam int unsigned PW    = (DECIM > 1) ? SH : 1;
  localparam int unsigned ACC_W = W + 4;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic [W-1:0]            mem_q [DEPTH];

  logic                    accept_c;
  logic                    last_c;
  logic signed [ACC_W-1:0] in_ext_c;
  logic signed [ACC_W-1:0] sum_c;
  logic [W-1:0]            result_c;
  logic                    push_c;
  logic                    pop_c;
  logic                    full_c;
  logic                    wr_en_c;

  // Datapath: sign-extend, accumulate, and scale the group sum down by DECIM.
  assign accept_c = in_valid & ~low_power_mode;
  assign last_c   = (phase_q == PW'(DECIM - 1));
  assign in_ext_c = {{(ACC_W - W){in_data[W-1]}}, in_data};
  assign sum_c    = acc_q + in_ext_c;
  assign result_c = W'(sum_c >>> SH);

  assign push_c  = accept_c & last_c;
  assign full_c  = (count_q == CW'(DEPTH));
  assign pop_c   = out_valid & out_ready;
  // While full, a write is only possible when the head leaves on the same edge.
  assign wr_en_c = push_c & (~full_c | pop_c);

  // Next-state for accumulator, pointers, occupancy and sticky overflow.
  always_comb begin
    acc_d    = acc_q;
    phase_d  = phase_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (accept_c) begin
      if (last_c) begin
        acc_d   = '0;
        phase_d = '0;
      end else begin
        acc_d   = sum_c;
        phase_d = phase_q + PW'(1);
      end
    end

    if (wr_en_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({wr_en_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push_c & ~wr_en_c) begin
      ovf_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      phase_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      phase_q  <= phase_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array; cleared on reset so the stale head reads as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      mem_q[wr_ptr_q] <= result_c;
    end
  end

  assign out_valid  = (count_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Bench for fir_decim_fifo: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based model.
module tb_fir_decim_fifo;

  localparam int W     = 16;
  localparam int DECIM = 4;
  localparam int DEPTH = 8;
  localparam int SH    = 2;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          low_power_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  always #5 clk = ~clk;

  fir_decim_fifo #(.W(W), .DECIM(DECIM), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .low_power_mode (low_power_mode),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .fifo_count     (fifo_count),
    .overflow       (overflow)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: queue of decimated results, integer accumulator.
  int mq[$];
  int macc   = 0;
  int mphase = 0;
  bit movf   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    macc   = 0;
    mphase = 0;
    movf   = 1'b0;
  endtask

  // Apply this edge's inputs to the model (called at the rising edge).
  task automatic model_edge();
    bit pop;
    bit push;
    int res;
    int s;
    pop  = (mq.size() != 0) && out_ready;
    push = 1'b0;
    res  = 0;
    if (in_valid && !low_power_mode) begin
      s = macc + int'($signed(in_data));
      if (mphase == DECIM - 1) begin
        res    = s >>> SH;
        push   = 1'b1;
        macc   = 0;
        mphase = 0;
      end else begin
        macc   = s;
        mphase = mphase + 1;
      end
    end
    if (push && mq.size() == DEPTH && !pop) begin
      movf = 1'b1;
      push = 1'b0;
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(res & 32'hFFFF);
  endtask

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("overflow", 32'(overflow), 32'(movf));
    if (mq.size() != 0) check("out_data", 32'(out_data), 32'(mq[0]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit v, input int d, input bit lp, input bit rdy);
    in_valid       = v;
    in_data        = W'(d);
    low_power_mode = lp;
    out_ready      = rdy;
  endtask

  task automatic feed(input int d, input bit rdy);
    drive(1'b1, d, 1'b0, rdy);
    step();
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, 0, 1'b0, rdy);
    step();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    model_clear();
    #2 reset = 1'b1;
  endtask

  initial begin
    drive(1'b0, 0, 1'b0, 1'b0);
    #3;
    check("init_rst_valid", 32'(out_valid), 32'd0);
    check("init_rst_count", 32'(fifo_count), 32'd0);
    check("init_rst_data", 32'(out_data), 32'd0);
    #10 reset = 1'b1;
    idle(1'b0);

    // Positive average.
    feed(4, 1'b1); feed(8, 1'b1); feed(12, 1'b1);
    check("pos_not_yet", 32'(out_valid), 32'd0);
    feed(16, 1'b1);
    check("pos_valid", 32'(out_valid), 32'd1);
    check("pos_avg", 32'(out_data), 32'd10);
    idle(1'b1);
    check("pos_drained", 32'(fifo_count), 32'd0);

    // Negative rounding toward minus infinity.
    feed(-1, 1'b0); feed(-2, 1'b0); feed(-3, 1'b0); feed(-4, 1'b0);
    check("neg_round", 32'(out_data), 32'h0000_FFFD);
    idle(1'b1);

    // Full-scale extremes.
    for (int i = 0; i < 4; i++) feed(32'h7FFF, 1'b0);
    check("max_pos", 32'(out_data), 32'h0000_7FFF);
    idle(1'b1);
    for (int i = 0; i < 4; i++) feed(-32768, 1'b0);
    check("max_neg", 32'(out_data), 32'h0000_8000);
    idle(1'b1);

    // Overflow: nine frames into an eight-entry FIFO with no consumer.
    for (int n = 1; n <= 9; n++)
      for (int i = 0; i < 4; i++) feed(n, 1'b0);
    check("ovf_count", 32'(fifo_count), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int n = 1; n <= 8; n++) begin
      check("ovf_drain", 32'(out_data), 32'(n));
      idle(1'b1);
    end
    check("ovf_empty", 32'(out_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Low power mid-frame: frozen samples must not contribute.
    do_reset();
    feed(4, 1'b1); feed(8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1000, 1'b1, 1'b1);
      step();
      check("lp_no_push", 32'(fifo_count), 32'd0);
    end
    feed(12, 1'b1); feed(16, 1'b1);
    check("lp_avg", 32'(out_data), 32'd10);
    idle(1'b1);

    // Full with simultaneous push and pop.
    for (int n = 1; n <= 8; n++)
      for (int i = 0; i < 4; i++) feed(n, 1'b0);
    feed(9, 1'b0); feed(9, 1'b0); feed(9, 1'b0);
    feed(9, 1'b1);
    check("pp_count", 32'(fifo_count), 32'd8);
    check("pp_noovf", 32'(overflow), 32'd0);
    for (int n = 2; n <= 9; n++) begin
      check("pp_drain", 32'(out_data), 32'(n));
      idle(1'b1);
    end

    // Reset mid-operation, then a clean frame.
    for (int n = 1; n <= 3; n++)
      for (int i = 0; i < 4; i++) feed(n, 1'b0);
    feed(50, 1'b0); feed(60, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) feed(2, 1'b0);
    check("post_rst_avg", 32'(out_data), 32'd2);
    check("post_rst_count", 32'(fifo_count), 32'd1);
    idle(1'b1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 3) != 0), int'($signed(16'($urandom))),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
